// File: rtl/rca64_pkg.sv
// Shared constants and types for the 64-bit ripple-carry accumulator.
package rca64_pkg;

   localparam int DATA_W = 64;

   typedef enum logic [1:0] {
      OP_ADD   = 2'b00,
      OP_SUB   = 2'b01,
      OP_LOAD  = 2'b10,
      OP_CLEAR = 2'b11
   } op_e;

   typedef enum logic {
      IDLE   = 1'b0,
      SETTLE = 1'b1
   } state_e;

   typedef struct packed {
      logic carry;
      logic overflow;
      logic zero;
      logic negative;
   } flags_t;

   // Flags for a value written directly (LOAD/CLEAR): no carry, no overflow.
   function automatic flags_t value_flags(input logic [DATA_W-1:0] v);
      flags_t f;
      f.carry    = 1'b0;
      f.overflow = 1'b0;
      f.zero     = (v == '0);
      f.negative = v[DATA_W-1];
      return f;
   endfunction

endpackage

// File: rtl/rca64_accumulator_if.sv
// Operand/opcode handshake and result/status bus of the accumulator.
interface rca64_accumulator_if;
   import rca64_pkg::*;

   logic              in_valid;
   logic              in_ready;
   logic [1:0]        op;
   logic [DATA_W-1:0] operand;
   logic [DATA_W-1:0] acc;
   logic              out_valid;
   logic              carry;
   logic              overflow;
   logic              zero;
   logic              negative;
   logic              busy;

   modport master (
      output in_valid, op, operand,
      input  in_ready, acc, out_valid, carry, overflow, zero, negative, busy
   );

   modport slave (
      input  in_valid, op, operand,
      output in_ready, acc, out_valid, carry, overflow, zero, negative, busy
   );

endinterface

// File: rtl/rca64_accumulator_rca.sv
// 64-bit ripple-carry adder: sum = a + b + c_in, carry propagating bit by bit.
module sixtyfourbitRCA
   import rca64_pkg::*;
(
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic              c_in,
   output logic [DATA_W-1:0] sum,
   output logic              c_out
);

   // Chain of full adders; the running carry is a local so the chain stays a single comb process.
   always_comb begin
      logic cy;
      cy  = c_in;
      sum = '0;
      for (int i = 0; i < DATA_W; i++) begin
         sum[i] = a[i] ^ b[i] ^ cy;
         cy     = (a[i] & b[i]) | (cy & (a[i] ^ b[i]));
      end
      c_out = cy;
   end

endmodule

// File: rtl/rca64_accumulator.sv
// Multicycle accumulator around the ripple-carry adder. ADD/SUB register the
// second operand, give the carry chain SETTLE_CYCLES cycles, then commit.
// LOAD/CLEAR commit at the accept edge. SETTLE_CYCLES legal range is 1..15.
module rca64_accumulator
   import rca64_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES = 2
)(
   input  logic                 clk,
   input  logic                 rst,
   rca64_accumulator_if.slave   bus
);

   localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

   state_e            state_q, state_d;
   logic [3:0]        cnt_q, cnt_d;
   logic [DATA_W-1:0] acc_q, acc_d;
   logic [DATA_W-1:0] b_q, b_d;
   logic              cin_q, cin_d;
   flags_t            flags_q, flags_d;
   logic              out_valid_q, out_valid_d;

   logic [DATA_W-1:0] sum;
   logic              c_out;
   logic              accept;

   // Adder sees only registered inputs, stable for the whole SETTLE window.
   sixtyfourbitRCA u_rca (
      .a     (acc_q),
      .b     (b_q),
      .c_in  (cin_q),
      .sum   (sum),
      .c_out (c_out)
   );

   assign accept = bus.in_valid && (state_q == IDLE);

   // Next-state, datapath and flag update.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      acc_d       = acc_q;
      b_d         = b_q;
      cin_d       = cin_q;
      flags_d     = flags_q;
      out_valid_d = 1'b0;

      case (state_q)
         IDLE: begin
            if (accept) begin
               case (op_e'(bus.op))
                  OP_LOAD: begin
                     acc_d       = bus.operand;
                     flags_d     = value_flags(bus.operand);
                     out_valid_d = 1'b1;
                  end
                  OP_CLEAR: begin
                     acc_d       = '0;
                     flags_d     = value_flags('0);
                     out_valid_d = 1'b1;
                  end
                  OP_SUB: begin
                     // acc - x == acc + ~x + 1
                     b_d     = ~bus.operand;
                     cin_d   = 1'b1;
                     cnt_d   = CNT_INIT;
                     state_d = SETTLE;
                  end
                  default: begin
                     b_d     = bus.operand;
                     cin_d   = 1'b0;
                     cnt_d   = CNT_INIT;
                     state_d = SETTLE;
                  end
               endcase
            end
         end
         SETTLE: begin
            if (cnt_q != '0) begin
               cnt_d = cnt_q - 4'd1;
            end else begin
               acc_d            = sum;
               flags_d.carry    = c_out;
               flags_d.overflow = (acc_q[DATA_W-1] == b_q[DATA_W-1]) &&
                                  (sum[DATA_W-1] != acc_q[DATA_W-1]);
               flags_d.zero     = (sum == '0);
               flags_d.negative = sum[DATA_W-1];
               out_valid_d      = 1'b1;
               state_d          = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State and datapath registers; reset abandons any in-flight operation.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         acc_q       <= '0;
         b_q         <= '0;
         cin_q       <= 1'b0;
         flags_q     <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         acc_q       <= acc_d;
         b_q         <= b_d;
         cin_q       <= cin_d;
         flags_q     <= flags_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.busy      = (state_q == SETTLE);
   assign bus.acc       = acc_q;
   assign bus.out_valid = out_valid_q;
   assign bus.carry     = flags_q.carry;
   assign bus.overflow  = flags_q.overflow;
   assign bus.zero      = flags_q.zero;
   assign bus.negative  = flags_q.negative;

endmodule
